// File: rtl/iterative_divider_if.sv
// Request/response bundle between the control unit and the iterative divider.
// Handshake: start is taken only while busy=0; once taken, busy stays high until done pulses for one cycle.
interface iterative_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider (DIV/DIVU): one trial subtraction per cycle, WIDTH iterations.
// Define DIV_SIGNED_EN to honour is_signed; otherwise every operation is unsigned.
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  iterative_divider_if.slave  bus,
  output logic [1:0]          dbg_state_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_out_q, quot_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_out_q, dbz_out_d;
  logic             done_q, done_d;

  logic             signed_op;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

`ifdef DIV_SIGNED_EN
  assign signed_op = bus.is_signed;
`else
  logic unused_is_signed;
  assign signed_op        = 1'b0;
  assign unused_is_signed = bus.is_signed;
`endif

  assign dvd_neg = signed_op & bus.dividend[WIDTH-1];
  assign dvs_neg = signed_op & bus.divisor[WIDTH-1];
  assign abs_dvd = dvd_neg ? -bus.dividend : bus.dividend;
  assign abs_dvs = dvs_neg ? -bus.divisor  : bus.divisor;

  // rem < |divisor| keeps the trial value inside WIDTH+1 signed bits.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_q      <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dbz_out_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dbz_q      <= dbz_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      dbz_out_q  <= dbz_out_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dbz_d      = dbz_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    dbz_out_d  = dbz_out_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            // Divide-by-zero skips the iterations; FIX passes the raw dividend through.
            quo_d     = '1;
            rem_d     = bus.dividend;
            dvs_d     = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            dbz_d     = 1'b1;
            state_d   = S_FIX;
          end else begin
            quo_d     = abs_dvd;
            rem_d     = '0;
            dvs_d     = abs_dvs;
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
            dbz_d     = 1'b0;
            cnt_d     = CW'(WIDTH - 1);
            state_d   = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_FIX: begin
        quot_out_d = neg_quo_q ? -quo_q : quo_q;
        rem_out_d  = neg_rem_q ? -rem_q : rem_q;
        dbz_out_d  = dbz_q;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quot_out_q;
  assign bus.remainder   = rem_out_q;
  assign bus.div_by_zero = dbz_out_q;
  assign dbg_state_o     = state_q;

endmodule
